// File: rtl/pipeline_interlock_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_interlock_ctrl
//
// Hazard and interlock controller for the 5-stage TinyRISC pipeline
// (IF, OF, EX, MA, WB). It works alongside the forwarding unit and covers the
// cases that forwarding cannot:
//   * load-use: a ld in EX whose destination is read by the instruction in OF.
//     The PC and IF/OF are held for one cycle and a nop enters OF/EX.
//   * multi-cycle mul/div/mod: the instruction holds EX for L cycles. The
//     front end is frozen for the first L-1 cycles and nops drain into EX/MA.
//   * taken branches: IF/OF and OF/EX are flushed.
// It also keeps a saturating count of the cycles in which the PC was stalled.
//
// All controls are level signals, valid in the same cycle as the instruction
// words that produce them. No valid/ready handshake is involved: every output
// is a pure function of the inputs, the FSM state and the occupancy counter.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset; forces all controls to 0
//   instruction_OF in   32-bit instruction in the IF/OF latch
//   instruction_EX in   32-bit instruction in the OF/EX latch
//   branch_taken   in   EX resolved a taken beq/bgt/b/call/ret this cycle
//   pc_stall       out  hold PC and IF/OF latch
//   of_ex_stall    out  hold OF/EX latch
//   of_ex_bubble   out  load nop into OF/EX
//   ex_ma_bubble   out  load nop into EX/MA
//   if_of_flush    out  replace IF/OF contents with nop
//   of_ex_flush    out  replace OF/EX contents with nop
//   ex_busy        out  multi-cycle operation occupying EX
//   stall_cycles   out  saturating count of cycles with pc_stall=1
//   state_dbg      out  FSM state (0 = IDLE, 1 = BUSY), for observation only
// -----------------------------------------------------------------------------
module pipeline_interlock_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction_OF,
  input  logic [31:0]      instruction_EX,
  input  logic             branch_taken,
  output logic             pc_stall,
  output logic             of_ex_stall,
  output logic             of_ex_bubble,
  output logic             ex_ma_bubble,
  output logic             if_of_flush,
  output logic             of_ex_flush,
  output logic             ex_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             state_dbg
);

  // ---------------------------------------------------------------------------
  // TinyRISC opcodes used by the interlock logic
  // ---------------------------------------------------------------------------
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  // The occupancy counter only ever holds L-2, so clog2(max L) bits suffice.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int LAT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [LAT_W-1:0] MUL_LOAD = (MUL_LAT > 1) ? LAT_W'(MUL_LAT - 2) : '0;
  localparam logic [LAT_W-1:0] DIV_LOAD = (DIV_LAT > 1) ? LAT_W'(DIV_LAT - 2) : '0;
  localparam logic             MUL_MULTI = (MUL_LAT > 1);
  localparam logic             DIV_MULTI = (DIV_LAT > 1);

  // ---------------------------------------------------------------------------
  // Instruction decode. An instruction word containing X/Z anywhere decodes as
  // a nop so that an uninitialised latch never fabricates a hazard.
  // ---------------------------------------------------------------------------
  logic       of_unknown;
  logic       ex_unknown;
  logic [4:0] of_op;
  logic [4:0] ex_op;
  logic       of_imm;
  logic [3:0] of_rs1;
  logic [3:0] of_rs2;
  logic [3:0] ex_rd;

  assign of_unknown = $isunknown(instruction_OF);
  assign ex_unknown = $isunknown(instruction_EX);
  assign of_op      = of_unknown ? OP_NOP : instruction_OF[31:27];
  assign ex_op      = ex_unknown ? OP_NOP : instruction_EX[31:27];
  assign of_imm     = instruction_OF[26];
  assign of_rs1     = instruction_OF[21:18];
  assign of_rs2     = instruction_OF[17:14];
  assign ex_rd      = instruction_EX[25:22];

  // The rd field of a st in OF is its data source, but WB->MA forwarding
  // supplies it in time, so OF's rd field never contributes to a hazard.
  logic unused_fields;
  assign unused_fields = ^{instruction_OF[25:22], instruction_OF[13:0],
                           instruction_EX[26], instruction_EX[21:0]};

  // ---------------------------------------------------------------------------
  // Source-register usage of the instruction in OF
  // ---------------------------------------------------------------------------
  logic of_reads_rs1;
  logic of_reads_rs2;
  logic of_reads_ra;

  always_comb begin
    case (of_op)
      OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET, OP_MOV, OP_NOT:
        of_reads_rs1 = 1'b0;
      default:
        of_reads_rs1 = 1'b1;
    endcase
  end

  // Register-form ALU ops (add..asr) read rs2; mov/not carry only one source.
  assign of_reads_rs2 = !of_imm && (of_op <= OP_ASR) &&
                        (of_op != OP_MOV) && (of_op != OP_NOT);
  // ret reads the return address register r15 implicitly.
  assign of_reads_ra  = (of_op == OP_RET);

  logic load_use;
  assign load_use = (ex_op == OP_LD) &&
                    ((of_reads_rs1 && (of_rs1 == ex_rd)) ||
                     (of_reads_rs2 && (of_rs2 == ex_rd)) ||
                     (of_reads_ra  && (ex_rd == 4'd15)));

  // ---------------------------------------------------------------------------
  // Multi-cycle EX occupancy
  // ---------------------------------------------------------------------------
  logic             ex_is_mul;
  logic             ex_is_divmod;
  logic             start_multi;
  logic [LAT_W-1:0] ex_load;

  assign ex_is_mul    = (ex_op == OP_MUL);
  assign ex_is_divmod = (ex_op == OP_DIV) || (ex_op == OP_MOD);
  // Single-cycle configurations never freeze the pipeline.
  assign start_multi  = (ex_is_mul && MUL_MULTI) || (ex_is_divmod && DIV_MULTI);
  assign ex_load      = ex_is_mul ? MUL_LOAD : DIV_LOAD;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [LAT_W-1:0] cnt;

  // IDLE -> BUSY on the first cycle of a multi-cycle op, loading L-2.
  // BUSY counts down; the cycle with cnt==0 is the release cycle in which the
  // op completes and leaves EX at the following edge. Returning to IDLE means a
  // back-to-back mul/div is seen afresh and gets its own full freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_multi) begin
            cnt   <= ex_load;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  logic freeze;
  assign freeze    = (state == BUSY) ? (cnt != '0) : start_multi;
  assign state_dbg = (state == BUSY);

  // ---------------------------------------------------------------------------
  // Control outputs. Priority: reset, freeze, flush, load-use. A flush wins
  // over load-use because the dependent instruction in OF is being discarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_stall     = 1'b0;
    of_ex_stall  = 1'b0;
    of_ex_bubble = 1'b0;
    ex_ma_bubble = 1'b0;
    if_of_flush  = 1'b0;
    of_ex_flush  = 1'b0;
    ex_busy      = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_stall     = 1'b1;
        of_ex_stall  = 1'b1;
        ex_ma_bubble = 1'b1;
        ex_busy      = 1'b1;
      end else if (branch_taken) begin
        if_of_flush  = 1'b1;
        of_ex_flush  = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        of_ex_bubble = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (pc_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_interlock_ctrl
//
// Self-checking bench for pipeline_interlock_ctrl. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge. Expected values come
// from directed constants and from a reference model that reasons in terms of
// "registers read by OF" and "cycles an op occupies EX".
// -----------------------------------------------------------------------------
module tb_pipeline_interlock_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam int CNT_W   = 16;

  // Control vector order: {pc_stall, of_ex_stall, of_ex_bubble, ex_ma_bubble,
  //                        if_of_flush, of_ex_flush, ex_busy}
  localparam logic [6:0] FROZEN = 7'b1101001;
  localparam logic [6:0] FLUSH  = 7'b0000110;
  localparam logic [6:0] LDUSE  = 7'b1010000;
  localparam logic [6:0] QUIET  = 7'b0000000;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  logic             clk;
  logic             rst;
  logic [31:0]      instruction_OF;
  logic [31:0]      instruction_EX;
  logic             branch_taken;
  logic             pc_stall;
  logic             of_ex_stall;
  logic             of_ex_bubble;
  logic             ex_ma_bubble;
  logic             if_of_flush;
  logic             of_ex_flush;
  logic             ex_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic             state_dbg;

  logic [6:0] ctl;
  assign ctl = {pc_stall, of_ex_stall, of_ex_bubble, ex_ma_bubble,
                if_of_flush, of_ex_flush, ex_busy};

  pipeline_interlock_ctrl #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instruction_OF(instruction_OF),
    .instruction_EX(instruction_EX),
    .branch_taken  (branch_taken),
    .pc_stall      (pc_stall),
    .of_ex_stall   (of_ex_stall),
    .of_ex_bubble  (of_ex_bubble),
    .ex_ma_bubble  (ex_ma_bubble),
    .if_of_flush   (if_of_flush),
    .of_ex_flush   (of_ex_flush),
    .ex_busy       (ex_busy),
    .stall_cycles  (stall_cycles),
    .state_dbg     (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping and reference model
  // ---------------------------------------------------------------------------
  int               n_pass;
  int               n_total;
  logic [CNT_W-1:0] exp_cnt;
  logic [6:0]       got_ctl;
  logic [CNT_W-1:0] got_cnt;
  logic             got_st;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic imm,
                                     input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [3:0] rs2);
    return {op, imm, rd, rs1, rs2, 14'd0};
  endfunction

  // Set of architectural registers the instruction in OF needs as sources.
  function automatic logic [15:0] read_set(input logic [31:0] i);
    logic [15:0] s;
    logic [4:0]  op;
    s  = '0;
    op = i[31:27];
    if (op == OP_RET) s[15] = 1'b1;
    if (!(op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET, OP_MOV, OP_NOT}))
      s[i[21:18]] = 1'b1;
    if (!i[26] && (op <= OP_ASR) && !(op inside {OP_MOV, OP_NOT}))
      s[i[17:14]] = 1'b1;
    return s;
  endfunction

  // Expected controls in a cycle where EX is not in a freeze cycle.
  function automatic logic [6:0] exp_open(input logic [31:0] ex, input logic [31:0] of,
                                          input logic br);
    logic [15:0] rs;
    rs = read_set(of);
    if (br) return FLUSH;
    if ((ex[31:27] == OP_LD) && rs[ex[25:22]]) return LDUSE;
    return QUIET;
  endfunction

  // Number of cycles the instruction stays in EX.
  function automatic int occupancy(input logic [31:0] ex);
    case (ex[31:27])
      OP_MUL:         return MUL_LAT;
      OP_DIV, OP_MOD: return DIV_LAT;
      default:        return 1;
    endcase
  endfunction

  // Counter model: cleared by reset, +1 per stalled cycle, saturating.
  function automatic void advance(input logic r, input logic [6:0] e);
    if (r) exp_cnt = '0;
    else if (e[6] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
  endfunction

  function automatic logic [3:0] rand_reg();
    int unsigned v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 4'd15 : 4'(v);
  endfunction

  function automatic logic [31:0] rand_ex();
    int unsigned  sel;
    logic [4:0]   op;
    sel = $urandom_range(0, 19);
    if (sel < 8)       op = OP_LD;
    else if (sel < 10) op = OP_MUL;
    else if (sel < 11) op = OP_DIV;
    else if (sel < 12) op = OP_MOD;
    else               op = 5'($urandom_range(0, 20));
    return mk(op, 1'($urandom_range(0, 1)), rand_reg(), rand_reg(), rand_reg());
  endfunction

  function automatic logic [31:0] rand_of();
    return mk(5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
              rand_reg(), rand_reg(), rand_reg());
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs and capture the outputs mid-cycle.
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic r, input logic [31:0] ex,
                             input logic [31:0] of, input logic br);
    @(posedge clk);
    #1;
    rst            = r;
    instruction_EX = ex;
    instruction_OF = of;
    branch_taken   = br;
    @(negedge clk);
    got_ctl = ctl;
    got_cnt = stall_cycles;
    got_st  = state_dbg;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] nop;
    nop = mk(OP_NOP, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, mk(OP_MUL, 0, 1, 2, 3), mk(OP_ADD, 0, 4, 1, 1), 1'b1);
      n_total++;
      if (got_ctl !== QUIET) $display("FAIL reset_ctl cycle=%0d got=%b want=%b", k, got_ctl, QUIET);
      else n_pass++;
      advance(1'b1, QUIET);
    end
    drive_cycle(1'b0, nop, nop, 1'b0);
    n_total++;
    if (got_ctl !== QUIET) $display("FAIL post_reset_ctl got=%b want=%b", got_ctl, QUIET);
    else n_pass++;
    n_total++;
    if (got_cnt !== '0) $display("FAIL post_reset_cnt got=%0d want=0", got_cnt);
    else n_pass++;
    n_total++;
    if (got_st !== 1'b0) $display("FAIL post_reset_state got=%b want=0", got_st);
    else n_pass++;
    advance(1'b0, QUIET);
  endtask

  task automatic test_load_use();
    logic [31:0] exs [4];
    logic [31:0] ofs [4];
    logic [6:0]  want[4];
    logic [31:0] ld3;
    ld3 = mk(OP_LD, 1, 3, 4, 0);
    exs[0] = ld3; ofs[0] = mk(OP_ADD, 0, 5, 3, 2); want[0] = LDUSE;  // add r5,r3,r2
    exs[1] = ld3; ofs[1] = mk(OP_ADD, 1, 5, 2, 3); want[1] = QUIET;  // add r5,r2,#3
    exs[2] = ld3; ofs[2] = mk(OP_ST,  1, 3, 4, 0); want[2] = QUIET;  // st r3,4[r4]
    exs[3] = ld3; ofs[3] = mk(OP_ST,  1, 4, 3, 0); want[3] = LDUSE;  // st r4,4[r3]
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, exs[k], ofs[k], 1'b0);
      n_total++;
      if (got_ctl !== want[k]) $display("FAIL load_use_ctl case=%0d got=%b want=%b", k, got_ctl, want[k]);
      else n_pass++;
      n_total++;
      if (got_cnt !== exp_cnt) $display("FAIL load_use_cnt case=%0d got=%0d want=%0d", k, got_cnt, exp_cnt);
      else n_pass++;
      advance(1'b0, want[k]);
    end
    // The bubble has replaced the ld: no further stall, counter advanced once
    // per stalling case above (0 -> 1 after the first, 2 after the fourth).
    drive_cycle(1'b0, mk(OP_NOP, 0, 0, 0, 0), ofs[0], 1'b0);
    n_total++;
    if (got_ctl !== QUIET) $display("FAIL load_use_release got=%b want=%b", got_ctl, QUIET);
    else n_pass++;
    n_total++;
    if (got_cnt !== CNT_W'(2)) $display("FAIL load_use_count got=%0d want=2", got_cnt);
    else n_pass++;
    advance(1'b0, QUIET);
  endtask

  task automatic test_mul();
    logic [CNT_W-1:0] c0;
    logic [6:0]       want;
    logic             want_st;
    c0 = exp_cnt;
    for (int k = 0; k < MUL_LAT; k++) begin
      drive_cycle(1'b0, mk(OP_MUL, 0, 6, 1, 2), mk(OP_NOP, 0, 0, 0, 0), 1'b0);
      want    = (k < MUL_LAT - 1) ? FROZEN : QUIET;
      want_st = (k != 0);
      n_total++;
      if (got_ctl !== want) $display("FAIL mul_ctl cycle=%0d got=%b want=%b", k, got_ctl, want);
      else n_pass++;
      n_total++;
      if (got_st !== want_st) $display("FAIL mul_state cycle=%0d got=%b want=%b", k, got_st, want_st);
      else n_pass++;
      advance(1'b0, want);
    end
    drive_cycle(1'b0, mk(OP_NOP, 0, 0, 0, 0), mk(OP_NOP, 0, 0, 0, 0), 1'b0);
    n_total++;
    if (got_cnt !== c0 + CNT_W'(2)) $display("FAIL mul_count got=%0d want=%0d", got_cnt, c0 + CNT_W'(2));
    else n_pass++;
    n_total++;
    if (got_st !== 1'b0) $display("FAIL mul_idle got=%b want=0", got_st);
    else n_pass++;
    advance(1'b0, QUIET);
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] c0;
    logic [6:0]       want;
    logic [31:0]      ex;
    c0 = exp_cnt;
    for (int k = 0; k < 2 * DIV_LAT; k++) begin
      ex   = (k < DIV_LAT) ? mk(OP_DIV, 0, 7, 1, 2) : mk(OP_MOD, 0, 8, 7, 2);
      want = ((k % DIV_LAT) < DIV_LAT - 1) ? FROZEN : QUIET;
      drive_cycle(1'b0, ex, mk(OP_ADD, 0, 9, 1, 1), 1'b0);
      n_total++;
      if (got_ctl !== want) $display("FAIL divmod_ctl cycle=%0d got=%b want=%b", k, got_ctl, want);
      else n_pass++;
      advance(1'b0, want);
    end
    drive_cycle(1'b0, mk(OP_NOP, 0, 0, 0, 0), mk(OP_NOP, 0, 0, 0, 0), 1'b0);
    n_total++;
    if (got_cnt !== c0 + CNT_W'(14)) $display("FAIL divmod_count got=%0d want=%0d", got_cnt, c0 + CNT_W'(14));
    else n_pass++;
    advance(1'b0, QUIET);
  endtask

  task automatic test_flush();
    drive_cycle(1'b0, mk(OP_LD, 1, 3, 4, 0), mk(OP_ADD, 0, 1, 3, 3), 1'b1);
    n_total++;
    if (got_ctl !== FLUSH) $display("FAIL flush_over_ld got=%b want=%b", got_ctl, FLUSH);
    else n_pass++;
    advance(1'b0, FLUSH);
    drive_cycle(1'b0, mk(OP_BEQ, 0, 0, 0, 0), mk(OP_NOP, 0, 0, 0, 0), 1'b1);
    n_total++;
    if (got_ctl !== FLUSH) $display("FAIL flush_plain got=%b want=%b", got_ctl, FLUSH);
    else n_pass++;
    advance(1'b0, FLUSH);
  endtask

  task automatic test_reset_busy();
    logic [31:0] dv;
    logic [31:0] nop;
    dv  = mk(OP_DIV, 0, 7, 1, 2);
    nop = mk(OP_NOP, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, dv, nop, 1'b0);
      n_total++;
      if (got_ctl !== FROZEN) $display("FAIL rstbusy_pre cycle=%0d got=%b want=%b", k, got_ctl, FROZEN);
      else n_pass++;
      advance(1'b0, FROZEN);
    end
    drive_cycle(1'b1, dv, nop, 1'b0);
    n_total++;
    if (got_ctl !== QUIET) $display("FAIL rstbusy_during got=%b want=%b", got_ctl, QUIET);
    else n_pass++;
    advance(1'b1, QUIET);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, nop, nop, 1'b0);
      n_total++;
      if (got_ctl !== QUIET || got_st !== 1'b0)
        $display("FAIL rstbusy_after cycle=%0d got=%b/%b want=%b/0", k, got_ctl, got_st, QUIET);
      else n_pass++;
      n_total++;
      if (got_cnt !== '0) $display("FAIL rstbusy_count cycle=%0d got=%0d want=0", k, got_cnt);
      else n_pass++;
      advance(1'b0, QUIET);
    end
  endtask

  task automatic test_random_mix();
    logic [31:0] ex;
    logic [31:0] of;
    logic        br;
    logic [6:0]  want;
    int          lat;
    for (int n = 0; n < 250; n++) begin
      ex  = rand_ex();
      lat = occupancy(ex);
      for (int k = 0; k < lat; k++) begin
        of = rand_of();
        br = ($urandom_range(0, 7) == 0);
        want = (k < lat - 1) ? FROZEN : exp_open(ex, of, br);
        drive_cycle(1'b0, ex, of, br);
        n_total++;
        if (got_ctl !== want)
          $display("FAIL random_ctl n=%0d k=%0d ex=%h of=%h br=%b got=%b want=%b",
                   n, k, ex, of, br, got_ctl, want);
        else n_pass++;
        n_total++;
        if (got_cnt !== exp_cnt) $display("FAIL random_cnt n=%0d got=%0d want=%0d", n, got_cnt, exp_cnt);
        else n_pass++;
        advance(1'b0, want);
      end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] ld3;
    logic [31:0] use3;
    ld3  = mk(OP_LD, 1, 3, 4, 0);
    use3 = mk(OP_ADD, 0, 5, 3, 2);
    for (int k = 0; k < 65538; k++) begin
      drive_cycle(1'b0, ld3, use3, 1'b0);
      advance(1'b0, LDUSE);
    end
    n_total++;
    if (got_cnt !== 16'hFFFF) $display("FAIL sat_reach got=%h want=ffff", got_cnt);
    else n_pass++;
    drive_cycle(1'b0, ld3, use3, 1'b0);
    n_total++;
    if (got_ctl !== LDUSE) $display("FAIL sat_ctl got=%b want=%b", got_ctl, LDUSE);
    else n_pass++;
    advance(1'b0, LDUSE);
    drive_cycle(1'b0, mk(OP_NOP, 0, 0, 0, 0), use3, 1'b0);
    n_total++;
    if (got_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h want=ffff", got_cnt);
    else n_pass++;
    advance(1'b0, QUIET);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_pass         = 0;
    n_total        = 0;
    exp_cnt        = '0;
    rst            = 1'b1;
    instruction_EX = mk(OP_NOP, 0, 0, 0, 0);
    instruction_OF = mk(OP_NOP, 0, 0, 0, 0);
    branch_taken   = 1'b0;

    test_reset();
    test_load_use();
    test_mul();
    test_back_to_back();
    test_flush();
    test_random_mix();
    test_reset_busy();
    test_saturate();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_interlock_ctrl.md
Name: pipeline_interlock_ctrl

Overview:
- Hazard/interlock controller for the 5-stage TinyRISC pipeline (IF, OF, EX, MA, WB); complements the forwarding unit.
- Detects load-use hazards that forwarding cannot cover and sequences multi-cycle mul/div/mod occupancy of EX.
- Turns taken branches into flushes.
- Drives stall, bubble and flush controls for the PC and the IF/OF, OF/EX and EX/MA latches, and keeps a saturating stall-cycle counter.

Parameters:
- MUL_LAT, 3, EX cycles for mul (opcode 00010); must be at least 1.
- DIV_LAT, 8, EX cycles for div (00011) and mod (00100); must be at least 1.
- CNT_W, 16, width of stall_cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- instruction_OF  in  32  instruction in the IF/OF latch.
- instruction_EX  in  32  instruction in the OF/EX latch.
- branch_taken  in  1  EX resolved a taken beq/bgt/b/call/ret this cycle.
- pc_stall  out  1  hold PC and IF/OF latch.
- of_ex_stall  out  1  hold OF/EX latch.
- of_ex_bubble  out  1  load nop (opcode 01101) into OF/EX.
- ex_ma_bubble  out  1  load nop into EX/MA.
- if_of_flush  out  1  replace IF/OF contents with nop.
- of_ex_flush  out  1  replace OF/EX contents with nop.
- ex_busy  out  1  multi-cycle operation occupying EX.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1.

Behaviour:
- Instruction fields: opcode [31:27], imm flag [26], rd [25:22], rs1 [21:18], rs2 [17:14]. Field X values are treated as nop.
- State machine: IDLE and BUSY, with down-counter cnt.
  - IDLE: if EX holds a mul/div/mod with latency L>1, assert freeze, load cnt=L-2, go to BUSY. If L=1, no freeze.
  - BUSY, cnt!=0: assert freeze, decrement cnt.
  - BUSY, cnt==0: deassert freeze, go to IDLE. The instruction leaves EX at this edge.
  - Total EX occupancy is L cycles, with L-1 freeze cycles.
  - A second mul/div arriving immediately afterwards restarts the sequence from IDLE, so it gets a full L-1 freeze cycles.
- Freeze drives pc_stall=1, of_ex_stall=1, ex_ma_bubble=1, ex_busy=1. During freeze, of_ex_bubble=0 and the flush outputs are 0.
- Load-use (evaluated only when not frozen): EX opcode is ld (01110) and OF reads the ld's rd.
  - OF reads rs1 for every opcode except nop, b, beq, bgt, call, ret, mov, not.
  - OF reads rs2 when imm=0 and opcode is an ALU op (00000 to 01100, excluding mov/not).
  - OF reads r15 for ret.
  - A st in OF whose data register (rd field) matches does NOT stall; WB->MA forwarding covers it.
  - Response: pc_stall=1, of_ex_bubble=1 for exactly 1 cycle, all other outputs 0.
- Branch: branch_taken=1 while not frozen drives if_of_flush=1 and of_ex_flush=1.
  - A flush overrides a simultaneous load-use: pc_stall=0, of_ex_bubble=0.
- All controls are combinational from the current inputs, state and cnt. There is no extra latency.
- stall_cycles is registered. It increments on each edge where pc_stall=1 and holds at 2^CNT_W-1.
- Reset: when rst=1 at an edge, state=IDLE, cnt=0, stall_cycles=0. While rst=1, all control outputs are forced to 0.
- Reset in BUSY aborts the operation. The first post-reset cycle is IDLE and re-evaluates EX afresh.

Test Plan:
1. EX=ld r3,0[r4]; OF=add r5,r3,r2 -> pc_stall=1 and of_ex_bubble=1 for 1 cycle, stall_cycles 0->1. OF=add r5,r2,#3 with imm rs2 field=3 -> no stall.
2. EX=ld r3; OF=st r3,4[r4] -> no stall. OF=st r4,4[r3] -> 1-cycle stall.
3. MUL_LAT=3, EX=mul -> pc_stall, of_ex_stall, ex_ma_bubble and ex_busy high for 2 cycles, low in cycle 3; stall_cycles=2.
4. DIV_LAT=8, div immediately followed by mod -> 7 freeze cycles, 1 release cycle, 7 freeze cycles; stall_cycles=14.
5. branch_taken=1 with EX=ld r3 and OF=add r1,r3,r3 -> if_of_flush=1, of_ex_flush=1, pc_stall=0, of_ex_bubble=0.
6. rst=1 in the 3rd cycle of a div -> next cycle all outputs 0, stall_cycles=0. EX=nop afterwards -> stays IDLE.
7. Force stall_cycles to 0xFFFF, then a load-use stall -> stall_cycles stays at 0xFFFF.
